spi_mst: RTL and testbench
==========================

# spi_mst

Single-clock SPI initiator that generates 24-bit register-access frames for the power-chip SPI slave: cmd(8) + data(8) + crc8(16→8). During each frame it captures the 24-bit slave response on MISO, which always carries the result of the *previous* frame. The block sits in the test/host-side controller and faces a simple request/response port.

## Interface
Parameters:
- REG_AW, 7, register address width (cmd[6:0])
- REG_DW, 8, register data width
- REG_CRC_W, 8, CRC width
- SCLK_DIV, 4, i_clk cycles per SCLK half-period; minimum 2
- GAP_CYC, 1200, minimum i_clk cycles CSB stays high between frames; minimum 1

Ports:
- i_clk  in  1  system clock; all logic is in this single clock domain
- i_rst  in  1  synchronous, active-high reset
- i_req  in  1  access request, qualified by o_ready
- i_wr  in  1  1 = write, 0 = read
- i_addr  in  REG_AW  register address
- i_wdata  in  REG_DW  write data (sent as 0 on reads)
- o_ready  out  1  high only in IDLE
- o_rsp_vld  out  1  one-cycle pulse at end of every frame
- o_rsp_status  out  1  response bit 23 (1 = write ack, 0 = read ack)
- o_rsp_addr  out  REG_AW  response bits 22:16
- o_rsp_data  out  REG_DW  response bits 15:8
- o_rsp_crc_err  out  1  response CRC mismatch
- o_rsp_first  out  1  this response belongs to the first frame after reset (no valid predecessor)
- o_spi_sclk  out  1  SPI clock, idles high
- o_spi_csb  out  1  chip select, active low
- o_spi_mosi  out  1  master data out
- i_spi_miso  in  1  slave data in, async; passes through a 2-flop gnrl_sync

## Operation
- SPI mode 3 (CPOL=1, CPHA=1). Master changes MOSI on SCLK falling edges; both sides sample on rising edges. Bits go MSB first.
- Tx frame = {i_wr, i_addr, wdata, crc}. crc = crc16to8_parallel({i_wr, i_addr, wdata}), the same CRC module the slave uses.
- Handshake: request is accepted when i_req & o_ready; all fields are latched on that cycle. i_req outside IDLE is ignored, not queued.
- State machine:
  - IDLE: CSB=1, SCLK=1, MOSI=0. Accept → SETUP.
  - SETUP: CSB=0, SCLK=1 for SCLK_DIV cycles → SHIFT.
  - SHIFT: 24 bits. Each bit is SCLK low for SCLK_DIV cycles (MOSI updates on the first low cycle), then SCLK high for SCLK_DIV cycles. Synchronized MISO is shifted in on the last high cycle. After bit 24 → HOLD.
  - HOLD: SCLK=1, CSB=0 for SCLK_DIV cycles → GAP. CSB rises on entry to GAP.
  - GAP: CSB=1, count GAP_CYC cycles → IDLE.
- Response: on HOLD→GAP, update o_rsp_* from the 24-bit capture and pulse o_rsp_vld. The fields hold until the next pulse.
  - o_rsp_crc_err = crc16to8_parallel(rx[23:8]) != rx[7:0].
- o_rsp_first is 1 for the first response after reset and 0 afterwards.
- Bit counter is 5 bits (0..23); the divide counter is $clog2(SCLK_DIV) bits; the gap counter is $clog2(GAP_CYC+1) bits. No wrap-around beyond these ranges.
- Reset mid-frame: the next cycle forces IDLE with CSB=1. The partial frame is discarded, no o_rsp_vld is produced, and o_rsp_first is re-armed.

## Timing
- Reset values:
  - o_ready=1
  - o_rsp_vld=0, o_rsp_status=0, o_rsp_addr=0, o_rsp_data=0, o_rsp_crc_err=0, o_rsp_first=1
  - o_spi_sclk=1, o_spi_csb=1, o_spi_mosi=0
- Accept at cycle T: CSB falls at T+1. CSB stays low for (2+48)·SCLK_DIV cycles, which is 200 at the default.
- o_rsp_vld is asserted in the same cycle CSB rises.
- o_ready reasserts GAP_CYC cycles after CSB rises. Frame-to-frame period is therefore at least 1 + 50·SCLK_DIV + GAP_CYC cycles.
- The MISO sampling margin needs SCLK_DIV ≥ 2 to tolerate the 2-cycle sync latency.

## Configuration
- SPI_MST_CRC_CHK_EN defined: the response CRC checker is compiled in and o_rsp_crc_err works as described.
- SPI_MST_CRC_CHK_EN undefined: no Rx CRC instance; o_rsp_crc_err is tied to 0. Tx CRC generation is always present.

## Test plan
- Write addr 0x12, data 0xA5 → MOSI shows 0x92, 0xA5, crc16to8(0x92A5) MSB-first. CSB low for exactly 200 cycles; o_rsp_vld is one cycle and coincides with CSB rise.
- Bench slave drives MISO = {0x92, 0x34, crc16to8(0x9234)} → o_rsp_status=1, o_rsp_addr=0x12, o_rsp_data=0x34, o_rsp_crc_err=0.
- Same as above with MISO crc bit 0 flipped → o_rsp_crc_err=1. With SPI_MST_CRC_CHK_EN undefined → 0.
- Read addr 0x05 → MOSI cmd=0x05, data=0x00. First response after reset has o_rsp_first=1; the second frame has o_rsp_first=0.
- i_req held high continuously → CSB high ≥ 1200 cycles between frames; o_ready=0 throughout SETUP…GAP.
- i_rst pulsed at SHIFT bit 10 → next cycle CSB=1, SCLK=1, MOSI=0, o_ready=1; no o_rsp_vld; o_rsp_first=1.

Source files
------------

// File: rtl/spi_mst.sv
// ---------------------------------------------------------------------------------------------
// spi_mst: single-clock SPI initiator for 24-bit register-access frames
//
// Purpose
//   Builds one frame per request: {wr, addr, wdata, crc8}. The CRC is taken over the 16-bit
//   payload. The frame is shifted out in SPI mode 3 (CPOL=1, CPHA=1), MSB first. At the same
//   time the 24-bit slave response is captured from MISO. That response belongs to the
//   *previous* frame. Fields are published on o_rsp_* with a one-cycle o_rsp_vld pulse,
//   issued in the same cycle CSB rises.
//
// Compile-time option
//   SPI_MST_CRC_CHK_EN : when defined, the response CRC is checked and reported on
//                        o_rsp_crc_err. When undefined, o_rsp_crc_err is tied low.
//                        Tx CRC generation is always built.
//
// Ports
//   i_clk, i_rst            system clock, synchronous active-high reset
//   i_req, i_wr, i_addr,    request port; accepted when i_req & o_ready, fields latched then
//   i_wdata                 (wdata is forced to 0 for reads)
//   o_ready                 high only while idle
//   o_rsp_vld               one-cycle pulse at the end of every completed frame
//   o_rsp_status/addr/data  response bits 23 / 22:16 / 15:8, held until the next pulse
//   o_rsp_crc_err           response CRC mismatch
//   o_rsp_first             response of the first frame since reset (no valid predecessor)
//   o_spi_sclk/csb/mosi     SPI outputs, all registered (SCLK idles high, CSB active low)
//   i_spi_miso              asynchronous slave data, resynchronised through two flops
// ---------------------------------------------------------------------------------------------
module spi_mst #(
    parameter int unsigned REG_AW    = 7,
    parameter int unsigned REG_DW    = 8,
    parameter int unsigned REG_CRC_W = 8,
    parameter int unsigned SCLK_DIV  = 4,
    parameter int unsigned GAP_CYC   = 1200
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_wr,
    input  logic [REG_AW-1:0] i_addr,
    input  logic [REG_DW-1:0] i_wdata,
    output logic              o_ready,
    output logic              o_rsp_vld,
    output logic              o_rsp_status,
    output logic [REG_AW-1:0] o_rsp_addr,
    output logic [REG_DW-1:0] o_rsp_data,
    output logic              o_rsp_crc_err,
    output logic              o_rsp_first,
    output logic              o_spi_sclk,
    output logic              o_spi_csb,
    output logic              o_spi_mosi,
    input  logic              i_spi_miso
);

    localparam int unsigned PayW   = 1 + REG_AW + REG_DW;
    localparam int unsigned FrameW = PayW + REG_CRC_W;
    localparam int unsigned DivW   = $clog2(SCLK_DIV);
    localparam int unsigned GapW   = $clog2(GAP_CYC + 1);

    localparam logic [4:0]           BitLast = 5'(FrameW - 1);
    localparam logic [DivW-1:0]      DivLast = DivW'(SCLK_DIV - 1);
    localparam logic [GapW-1:0]      GapLast = GapW'(GAP_CYC - 1);
    // CRC-8, x^8 + x^2 + x + 1, zero init, payload processed MSB first
    localparam logic [REG_CRC_W-1:0] CrcPoly = REG_CRC_W'(8'h07);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    // Same CRC the slave uses; unrolls into a parallel XOR network.
    function automatic logic [REG_CRC_W-1:0] crc16to8_parallel(input logic [PayW-1:0] din);
        logic [REG_CRC_W-1:0] c;
        logic                 fb;
        c = '0;
        for (int i = PayW - 1; i >= 0; i--) begin
            fb = c[REG_CRC_W-1] ^ din[i];
            c  = {c[REG_CRC_W-2:0], 1'b0};
            if (fb) begin
                c = c ^ CrcPoly;
            end
        end
        return c;
    endfunction

    state_e              state_q, state_d;
    logic [DivW-1:0]     div_q, div_d;
    logic                phase_q, phase_d;   // 0: SCLK low half, 1: SCLK high half
    logic [4:0]          bit_q, bit_d;
    logic [GapW-1:0]     gap_q, gap_d;
    logic [FrameW-1:0]   tx_q, tx_d;
    logic [FrameW-1:0]   rx_q, rx_d;
    logic                sclk_q, sclk_d;
    logic                csb_q, csb_d;
    logic                mosi_q, mosi_d;
    logic                miso_meta_q, miso_sync_q;
    logic                first_pend_q;
    logic                rsp_fire;
    logic                rx_crc_err;
    logic [REG_DW-1:0]   wdata_eff;
    logic [PayW-1:0]     tx_pay;

    assign wdata_eff = i_wr ? i_wdata : '0;
    assign tx_pay    = {i_wr, i_addr, wdata_eff};

`ifdef SPI_MST_CRC_CHK_EN
    assign rx_crc_err = (crc16to8_parallel(rx_q[FrameW-1 -: PayW]) != rx_q[REG_CRC_W-1:0]);
`else
    logic unused_rx_crc;
    assign unused_rx_crc = ^rx_q[REG_CRC_W-1:0];
    assign rx_crc_err    = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rsp_fire = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_req) begin
                    state_d = StSetup;
                    div_d   = '0;
                    tx_d    = {tx_pay, crc16to8_parallel(tx_pay)};
                end
            end
            StSetup: begin
                if (div_q == DivLast) begin
                    state_d = StShift;
                    div_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StShift: begin
                if (div_q != DivLast) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        // Last high cycle: the resynchronised MISO bit has been stable for
                        // several cycles since the slave's falling-edge update.
                        rx_d    = {rx_q[FrameW-2:0], miso_sync_q};
                        phase_d = 1'b0;
                        if (bit_q == BitLast) begin
                            state_d = StHold;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
            end
            StHold: begin
                if (div_q == DivLast) begin
                    state_d  = StGap;
                    gap_d    = '0;
                    rsp_fire = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // SPI pins are derived from the next state, so they can be registered and still change
    // in the same cycle as the state.
    always_comb begin
        sclk_d = ~((state_d == StShift) && !phase_d);
        csb_d  = (state_d == StIdle) || (state_d == StGap);
        mosi_d = mosi_q;
        if ((state_d == StShift) && !phase_d && (div_d == '0)) begin
            mosi_d = tx_q[BitLast - bit_d];
        end else if ((state_d == StIdle) || (state_d == StSetup) || (state_d == StGap)) begin
            mosi_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= StIdle;
            div_q         <= '0;
            phase_q       <= 1'b0;
            bit_q         <= '0;
            gap_q         <= '0;
            tx_q          <= '0;
            rx_q          <= '0;
            sclk_q        <= 1'b1;
            csb_q         <= 1'b1;
            mosi_q        <= 1'b0;
            miso_meta_q   <= 1'b0;
            miso_sync_q   <= 1'b0;
            first_pend_q  <= 1'b1;
            o_rsp_vld     <= 1'b0;
            o_rsp_status  <= 1'b0;
            o_rsp_addr    <= '0;
            o_rsp_data    <= '0;
            o_rsp_crc_err <= 1'b0;
            o_rsp_first   <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            sclk_q      <= sclk_d;
            csb_q       <= csb_d;
            mosi_q      <= mosi_d;
            miso_meta_q <= i_spi_miso;
            miso_sync_q <= miso_meta_q;
            o_rsp_vld   <= rsp_fire;
            if (rsp_fire) begin
                o_rsp_status  <= rx_q[FrameW-1];
                o_rsp_addr    <= rx_q[FrameW-2 -: REG_AW];
                o_rsp_data    <= rx_q[REG_CRC_W +: REG_DW];
                o_rsp_crc_err <= rx_crc_err;
                o_rsp_first   <= first_pend_q;
                first_pend_q  <= 1'b0;
            end
        end
    end

    assign o_ready    = (state_q == StIdle);
    assign o_spi_sclk = sclk_q;
    assign o_spi_csb  = csb_q;
    assign o_spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_mst.sv
// Self-checking bench for spi_mst: a behavioural mode-3 slave drives MISO and captures MOSI.
// A scoreboard queue holds the expected frame/response for each completed access.
module tb_spi_mst;

    localparam int unsigned SclkDiv  = 4;
    localparam int unsigned GapCyc   = 1200;
    localparam int unsigned CsbLow   = 50 * SclkDiv;
    localparam int unsigned WaitLim  = 1 + 50 * SclkDiv + GapCyc + 100;

    typedef struct packed {
        logic [23:0] mosi;
        logic        status;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic        crc_err;
        logic        first;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       wr = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       miso = 1'b0;

    logic       o_ready, o_rsp_vld, o_rsp_status, o_rsp_crc_err, o_rsp_first;
    logic [6:0] o_rsp_addr;
    logic [7:0] o_rsp_data;
    logic       o_spi_sclk, o_spi_csb, o_spi_mosi;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] slv_rsp = '0;
    bit          abort = 1'b0;
    bit          exp_first = 1'b1;

    // Monitor state (written only by the monitor process)
    logic [23:0] mosi_cap = '0;
    int          cap_n = 0;
    int          slv_idx = 0;
    int          low_cnt = 0;
    int          high_cnt = 0;
    int          rdy_cnt = 0;
    int          last_high = 0;
    int          last_rdy = 0;
    int          rdy_bad = 0;
    logic        csb_prev = 1'b1;
    logic        sclk_prev = 1'b1;
    logic        vld_prev = 1'b0;

    always #5 clk = ~clk;

    spi_mst #(
        .SCLK_DIV (SclkDiv),
        .GAP_CYC  (GapCyc)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_wr          (wr),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .o_ready       (o_ready),
        .o_rsp_vld     (o_rsp_vld),
        .o_rsp_status  (o_rsp_status),
        .o_rsp_addr    (o_rsp_addr),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_crc_err (o_rsp_crc_err),
        .o_rsp_first   (o_rsp_first),
        .o_spi_sclk    (o_spi_sclk),
        .o_spi_csb     (o_spi_csb),
        .o_spi_mosi    (o_spi_mosi),
        .i_spi_miso    (miso)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp_v);
        end
    endtask

    // CRC-8 (poly 0x107) as polynomial long division of {d, 8'h00}.
    function automatic logic [7:0] tb_crc(input logic [15:0] d);
        logic [23:0] r;
        r = {d, 8'h00};
        for (int i = 23; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic exp_t make_exp(input logic w, input logic [6:0] a, input logic [7:0] d,
                                      input logic [23:0] rsp, input logic first);
        exp_t        e;
        logic [15:0] pay;
        pay       = {w, a, (w ? d : 8'h00)};
        e.mosi    = {pay, tb_crc(pay)};
        e.status  = rsp[23];
        e.addr    = rsp[22:16];
        e.data    = rsp[15:8];
`ifdef SPI_MST_CRC_CHK_EN
        e.crc_err = (tb_crc(rsp[23:8]) != rsp[7:0]);
`else
        e.crc_err = 1'b0;
`endif
        e.first   = first;
        return e;
    endfunction

    function automatic logic [23:0] mk_rsp(input logic [15:0] hi, input logic [7:0] flip);
        return {hi, tb_crc(hi) ^ flip};
    endfunction

    // Slave model, MOSI capture, CSB timing and scoreboard, all sampled on the falling clk edge.
    always @(negedge clk) begin
        exp_t e;
        if (!o_spi_csb) begin
            if (csb_prev) begin
                cap_n     = 0;
                mosi_cap  = '0;
                slv_idx   = 0;
                low_cnt   = 0;
                last_high = high_cnt;
                last_rdy  = rdy_cnt;
            end
            low_cnt++;
            if (o_ready) rdy_bad++;
            if (sclk_prev && !o_spi_sclk && slv_idx < 24) begin
                miso = slv_rsp[23 - slv_idx];
                slv_idx++;
            end
            if (!sclk_prev && o_spi_sclk) begin
                mosi_cap = {mosi_cap[22:0], o_spi_mosi};
                cap_n++;
            end
        end else begin
            if (!csb_prev) begin
                if (!abort) check_val("csb_low_len", low_cnt, CsbLow);
                high_cnt = 0;
                rdy_cnt  = 0;
            end
            high_cnt++;
            if (o_ready) rdy_cnt++;
        end
        if (o_rsp_vld) begin
            check_val("vld_pulse", vld_prev, 0);
            check_val("vld_csb", o_spi_csb, 1);
            if (sb_q.size() == 0) begin
                check_val("vld_unexp", o_rsp_vld, 0);
            end else begin
                e = sb_q.pop_front();
                check_val("mosi_frame", mosi_cap, e.mosi);
                check_val("mosi_bits", cap_n, 24);
                check_val("rsp_status", o_rsp_status, e.status);
                check_val("rsp_addr", o_rsp_addr, e.addr);
                check_val("rsp_data", o_rsp_data, e.data);
                check_val("rsp_crc_err", o_rsp_crc_err, e.crc_err);
                check_val("rsp_first", o_rsp_first, e.first);
            end
        end
        vld_prev  = o_rsp_vld;
        csb_prev  = o_spi_csb;
        sclk_prev = o_spi_sclk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_ready && n < WaitLim) begin
            tick();
            n++;
        end
        if (!o_ready) check_val("ready_timeout", o_ready, 1);
    endtask

    task automatic start_frame(input logic w, input logic [6:0] a, input logic [7:0] d,
                               input logic [23:0] rsp, input bit push);
        wait_ready();
        slv_rsp = rsp;
        if (push) begin
            sb_q.push_back(make_exp(w, a, d, rsp, exp_first));
            exp_first = 1'b0;
        end
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        tick();
        req = 1'b0;
        check_val("csb_fall", o_spi_csb, 0);
        check_val("ready_busy", o_ready, 0);
    endtask

    initial begin
        logic [23:0] rsp;
        int          n;
        int          seen;

        // Reset values
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_val("rst_ready", o_ready, 1);
        check_val("rst_vld", o_rsp_vld, 0);
        check_val("rst_status", o_rsp_status, 0);
        check_val("rst_addr", o_rsp_addr, 0);
        check_val("rst_data", o_rsp_data, 0);
        check_val("rst_crc_err", o_rsp_crc_err, 0);
        check_val("rst_first", o_rsp_first, 1);
        check_val("rst_sclk", o_spi_sclk, 1);
        check_val("rst_csb", o_spi_csb, 1);
        check_val("rst_mosi", o_spi_mosi, 0);

        // Write 0x12/0xA5, slave returns a clean write ack
        start_frame(1'b1, 7'h12, 8'hA5, mk_rsp(16'h9234, 8'h00), 1'b1);
        wait_ready();
        // Read 0x05 with junk wdata (must go out as 0), response CRC corrupted in bit 0
        start_frame(1'b0, 7'h05, 8'hFF, mk_rsp(16'h9234, 8'h01), 1'b1);
        wait_ready();
        // Read ack
        start_frame(1'b0, 7'h05, 8'h00, mk_rsp(16'h055A, 8'h00), 1'b1);
        wait_ready();
        check_val("rsp_hold_data", o_rsp_data, 8'h5A);

        // Request held high across two frames
        rsp     = mk_rsp(16'hB377, 8'h00);
        slv_rsp = rsp;
        sb_q.push_back(make_exp(1'b1, 7'h33, 8'h77, rsp, exp_first));
        sb_q.push_back(make_exp(1'b1, 7'h33, 8'h77, rsp, 1'b0));
        exp_first = 1'b0;
        req   = 1'b1;
        wr    = 1'b1;
        addr  = 7'h33;
        wdata = 8'h77;
        n     = 0;
        seen  = 0;
        while (seen < 2 && n < 2 * WaitLim) begin
            if (o_ready) seen++;
            if (seen < 2) tick();
            n++;
        end
        if (seen < 2) check_val("b2b_timeout", o_ready, 1);
        tick();
        req = 1'b0;
        @(negedge clk);
        #1;
        check_val("b2b_csb", o_spi_csb, 0);
        check_val("b2b_gap_min", (last_high >= GapCyc), 1);
        check_val("b2b_ready_cyc", last_rdy, 1);
        wait_ready();

        // Reset in the middle of SHIFT, after ten bits
        start_frame(1'b1, 7'h44, 8'h99, mk_rsp(16'hC4C4, 8'h00), 1'b0);
        n = 0;
        while (cap_n < 10 && n < 1000) begin
            tick();
            n++;
        end
        if (cap_n < 10) check_val("bit10_timeout", cap_n, 10);
        abort = 1'b1;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_csb", o_spi_csb, 1);
        check_val("mid_rst_sclk", o_spi_sclk, 1);
        check_val("mid_rst_mosi", o_spi_mosi, 0);
        check_val("mid_rst_ready", o_ready, 1);
        check_val("mid_rst_vld", o_rsp_vld, 0);
        check_val("mid_rst_first", o_rsp_first, 1);
        repeat (20) tick();
        abort     = 1'b0;
        exp_first = 1'b1;

        // First frame after the abort must again be flagged as first
        start_frame(1'b0, 7'h7F, 8'h00, mk_rsp(16'h7FC3, 8'h00), 1'b1);
        wait_ready();
        repeat (5) tick();

        check_val("ready_during_frame", rdy_bad, 0);
        check_val("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
